// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed hex driver for common-anode 7-segment digits; define SEG7_LZB_EN for leading-zero blanking
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [DIV_WIDTH-1:0]    cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] act_d, pend_d;
    logic [NUM_DIGITS-1:0]   act_p, pend_p, sup;
    logic                    pend_vld, last, bnd, blk;
    logic [3:0]              nib;
    assign last = cnt == DIV_WIDTH'(SCAN_DIV - 1);
    assign bnd  = last && idx == IW'(NUM_DIGITS - 1);
    assign nib  = act_d[4*idx +: 4];
    assign blk  = blank[idx] | sup[idx];
`ifdef SEG7_LZB_EN
    logic run;
    // a digit above 0 is suppressed while it and every more-significant active nibble are zero
    always_comb begin
        run = 1'b1;
        sup = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run = run && act_d[4*k +: 4] == 4'h0;
            sup[k] = run;
        end
    end
`else
    assign sup = '0;
`endif
    // slot prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
        end
    end
    // pending/active buffers; active only changes at a frame boundary so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            act_d    <= '0;
            act_p    <= '0;
            pend_d   <= '0;
            pend_p   <= '0;
            pend_vld <= 1'b0;
        end else if (bnd) begin
            act_d    <= load ? din : pend_vld ? pend_d : act_d;
            act_p    <= load ? dp_in : pend_vld ? pend_p : act_p;
            pend_vld <= 1'b0;
        end else if (load) begin
            pend_d   <= din;
            pend_p   <= dp_in;
            pend_vld <= 1'b1;
        end
    end
    // registered pin drive; last cycle of each slot is a dead cycle with all anodes off
    always_ff @(posedge clk) begin
        if (rst) begin
            seg   <= 7'h7F;
            dp    <= 1'b1;
            an    <= '1;
            frame <= 1'b0;
        end else begin
            frame <= bnd;
            an    <= last ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg   <= (last || blk) ? 7'h7F : GLYPH[nib];
            dp    <= last || blank[idx] || !act_p[idx];
        end
    end
endmodule
